// File: rtl/alu_rr_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin grant, one op in flight.
// Latency: request accepted at cycle t, result valid at cycle t+2; minimum issue interval 3 cycles.
// Backpressure: a held response blocks both ports; req*_ready is only ever raised in IDLE.
module alu_rr_arbiter #(
  parameter int WIDTH = 32,
  parameter int FW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  // requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [FW-1:0]    req0_f,
  // requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [FW-1:0]    req1_f,
  // response 0
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_y,
  output logic             rsp0_zero,
  // response 1
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_y,
  output logic             rsp1_zero,
  // shared ALU
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [FW-1:0]    alu_f,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_zero,
  // status
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic             any_req;      // at least one requester is offering an op
  logic             pick;         // port that wins arbitration this cycle
  logic             accept;       // request handshake happens this cycle
  logic             gnt;          // port owning the in-flight op
  logic             last_served;  // port whose response completed most recently
  logic             rsp_hs;       // response handshake happens this cycle

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [FW-1:0]    op_f;

  logic [WIDTH-1:0] res0_y;
  logic             res0_zero;
  logic [WIDTH-1:0] res1_y;
  logic             res1_zero;

  // Arbitration: a lone requester wins; on a tie the port not served last wins.
  always_comb begin
    any_req = req0_valid | req1_valid;
    pick    = 1'b0;
    if (req0_valid && req1_valid) begin
      pick = ~last_served;
    end else if (req1_valid) begin
      pick = 1'b1;
    end
  end

  // Handshake qualifiers; rsp_hs never feeds req*_ready, only state/last_served.
  always_comb begin
    accept = (state == IDLE) && any_req;
    rsp_hs = (state == RESP) && (gnt ? rsp1_ready : rsp0_ready);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> EXEC -> RESP -> IDLE, EXEC lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: ready only in IDLE for the winner, valid only in RESP for the owner.
  always_comb begin
    req0_ready = accept && !pick;
    req1_ready = accept && pick;
    rsp0_valid = (state == RESP) && !gnt;
    rsp1_valid = (state == RESP) && gnt;
    busy       = (state != IDLE);
  end

  // Latch the winning operands and owner on the request handshake; they hold until the next grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a <= '0;
      op_b <= '0;
      op_f <= '0;
      gnt  <= 1'b0;
    end else if (accept) begin
      op_a <= pick ? req1_a : req0_a;
      op_b <= pick ? req1_b : req0_b;
      op_f <= pick ? req1_f : req0_f;
      gnt  <= pick;
    end
  end

  // Capture the ALU result at the end of EXEC into the owning port's result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res0_y    <= '0;
      res0_zero <= 1'b0;
      res1_y    <= '0;
      res1_zero <= 1'b0;
    end else if (state == EXEC) begin
      if (gnt) begin
        res1_y    <= alu_y;
        res1_zero <= alu_zero;
      end else begin
        res0_y    <= alu_y;
        res0_zero <= alu_zero;
      end
    end
  end

  // Fairness history advances only when a response is actually taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_served <= 1'b1;
    end else if (rsp_hs) begin
      last_served <= gnt;
    end
  end

  // Operand bus and results come straight from registers, so nothing toggles while idle.
  assign alu_a     = op_a;
  assign alu_b     = op_b;
  assign alu_f     = op_f;
  assign rsp0_y    = res0_y;
  assign rsp0_zero = res0_zero;
  assign rsp1_y    = res1_y;
  assign rsp1_zero = res1_zero;

endmodule
